// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: access-size encodings,
// the illegal-size check and the byte-lane to mem_write bit mapping.
package dmem_arb_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  // Lane 0 (bits 7:0) is enabled by mem_write[3]; lane k by LANE0_WE >> k.
  localparam logic [3:0] LANE0_WE = 4'b1000;

  function automatic logic is_sz_illegal(input logic [1:0] size);
    return size == SZ_ILLEGAL;
  endfunction

endpackage

// File: rtl/dmem_store_fmt.sv
// Combinational store formatter: byte-lane enables, lane-replicated store
// data and the misalignment / illegal-size flag for the granted request.
module dmem_store_fmt
  import dmem_arb_pkg::*;
(
  input  logic [1:0]        addr_lo,
  input  logic [1:0]        size,
  input  logic [DATA_W-1:0] wdata,
  output logic [3:0]        be,
  output logic [DATA_W-1:0] wdata_rep,
  output logic              bad
);

  always_comb begin
    be        = '0;
    wdata_rep = wdata;
    bad       = is_sz_illegal(size);
    case (size_e'(size))
      SZ_BYTE: begin
        be        = LANE0_WE >> addr_lo;
        wdata_rep = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be        = (LANE0_WE >> {addr_lo[1], 1'b0}) | (LANE0_WE >> {addr_lo[1], 1'b1});
        wdata_rep = {2{wdata[15:0]}};
        bad       = addr_lo[0];
      end
      SZ_WORD: begin
        be  = 4'b1111;
        bad = |addr_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-requester data-memory arbiter (CPU = m0, DMA/debug = m1).
// Define DMEM_ARB_RR_EN for round-robin arbitration; fixed m0 priority otherwise.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int BYTE_AW = 13,
  parameter int WORD_AW = 11
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_req,
  input  logic               m0_we,
  input  logic [BYTE_AW-1:0] m0_addr,
  input  logic [1:0]         m0_size,
  input  logic [DATA_W-1:0]  m0_wdata,
  output logic               m0_gnt,
  output logic               m0_rvalid,
  output logic [DATA_W-1:0]  m0_rdata,
  output logic               m0_err,
  input  logic               m1_req,
  input  logic               m1_we,
  input  logic [BYTE_AW-1:0] m1_addr,
  input  logic [1:0]         m1_size,
  input  logic [DATA_W-1:0]  m1_wdata,
  output logic               m1_gnt,
  output logic               m1_rvalid,
  output logic [DATA_W-1:0]  m1_rdata,
  output logic               m1_err,
  output logic               mem_en,
  output logic [3:0]         mem_write,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata
);

  logic               sel;
  logic               gnt_any;
  logic               bad;
  logic               g_we;
  logic [BYTE_AW-1:0] g_addr;
  logic [1:0]         g_size;
  logic [DATA_W-1:0]  g_wdata;
  logic [DATA_W-1:0]  fmt_wdata;
  logic [3:0]         fmt_be;
  logic               ld_vld_p1;
  logic               ld_own_p1;
  logic               err0_p1;
  logic               err1_p1;
  logic [DATA_W-1:0]  hold0_p1;
  logic [DATA_W-1:0]  hold1_p1;

`ifdef DMEM_ARB_RR_EN
  logic ptr;

  assign sel = (m0_req & m1_req) ? ptr : ~m0_req;

  // The pointer always moves to the requester that did not just win.
  always_ff @(posedge clk) begin
    if (rst)          ptr <= 1'b0;
    else if (gnt_any) ptr <= ~sel;
  end
`else
  assign sel = ~m0_req;
`endif

  assign gnt_any = (m0_req | m1_req) & ~rst;
  assign m0_gnt  = gnt_any & ~sel;
  assign m1_gnt  = gnt_any & sel;

  assign g_we    = sel ? m1_we    : m0_we;
  assign g_addr  = sel ? m1_addr  : m0_addr;
  assign g_size  = sel ? m1_size  : m0_size;
  assign g_wdata = sel ? m1_wdata : m0_wdata;

  dmem_store_fmt u_fmt (
    .addr_lo   (g_addr[1:0]),
    .size      (g_size),
    .wdata     (g_wdata),
    .be        (fmt_be),
    .wdata_rep (fmt_wdata),
    .bad       (bad)
  );

  assign mem_en    = gnt_any & ~bad;
  assign mem_write = (mem_en & g_we) ? fmt_be : 4'b0000;
  assign mem_addr  = rst ? '0 : g_addr[BYTE_AW-1:2];
  assign mem_wdata = rst ? '0 : fmt_wdata;

  // p0 -> p1: remember who owns the outstanding load and who gets an error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      ld_vld_p1 <= 1'b0;
      ld_own_p1 <= 1'b0;
      err0_p1   <= 1'b0;
      err1_p1   <= 1'b0;
    end else begin
      ld_vld_p1 <= mem_en & ~g_we;
      ld_own_p1 <= sel;
      err0_p1   <= m0_gnt & bad;
      err1_p1   <= m1_gnt & bad;
    end
  end

  always_ff @(posedge clk) begin
    if (m0_rvalid) hold0_p1 <= mem_rdata;
    if (m1_rvalid) hold1_p1 <= mem_rdata;
  end

  // A load granted just before reset is dropped by masking with rst.
  assign m0_rvalid = ld_vld_p1 & ~ld_own_p1 & ~rst;
  assign m1_rvalid = ld_vld_p1 & ld_own_p1 & ~rst;
  assign m0_err    = err0_p1 & ~rst;
  assign m1_err    = err1_p1 & ~rst;
  assign m0_rdata  = rst ? '0 : (m0_rvalid ? mem_rdata : hold0_p1);
  assign m1_rdata  = rst ? '0 : (m1_rvalid ? mem_rdata : hold1_p1);

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed scenarios followed by
// randomized traffic against a transaction-level reference model.
module tb_data_mem_arbiter;

`ifdef DMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [12:0] addr  [2];
  logic [1:0]  size  [2];
  logic [31:0] wdata [2];

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en;
  logic [3:0]  mem_write;
  logic [10:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  logic        gnt_o [2];
  logic        rv_o  [2];
  logic        err_o [2];
  logic [31:0] rd_o  [2];
  assign gnt_o[0] = m0_gnt;    assign gnt_o[1] = m1_gnt;
  assign rv_o[0]  = m0_rvalid; assign rv_o[1]  = m1_rvalid;
  assign err_o[0] = m0_err;    assign err_o[1] = m1_err;
  assign rd_o[0]  = m0_rdata;  assign rd_o[1]  = m1_rdata;

  data_mem_arbiter #(.BYTE_AW(13), .WORD_AW(11)) dut (
    .clk       (clk),
    .rst       (rst),
    .m0_req    (req[0]),
    .m0_we     (we[0]),
    .m0_addr   (addr[0]),
    .m0_size   (size[0]),
    .m0_wdata  (wdata[0]),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m0_err    (m0_err),
    .m1_req    (req[1]),
    .m1_we     (we[1]),
    .m1_addr   (addr[1]),
    .m1_size   (size[1]),
    .m1_wdata  (wdata[1]),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .m1_err    (m1_err),
    .mem_en    (mem_en),
    .mem_write (mem_write),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Synchronous RAM attached to the memory port.
  logic        clr;
  logic [31:0] ram [2048];
  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 2048; i++) ram[i] <= '0;
    end else if (mem_en) begin
      for (int k = 0; k < 4; k++)
        if (mem_write[3-k]) ram[mem_addr][8*k +: 8] <= mem_wdata[8*k +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [31:0] ref_mem [2048];
  int          ptr_m;
  int          pend_own;
  logic [31:0] pend_word;
  bit          err_pend  [2];
  logic [31:0] hold_m    [2];
  bit          hold_known[2];
  int          last_w;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare every output for the current cycle, then advance the model.
  task automatic cyc();
    int w, nb, off, a;
    bit bad;
    logic [3:0]  wr;
    logic [31:0] wd;
    @(negedge clk);
    w = -1;
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("rst_m%0d_gnt", n),    32'(gnt_o[n]), 0);
        chk($sformatf("rst_m%0d_rvalid", n), 32'(rv_o[n]),  0);
        chk($sformatf("rst_m%0d_err", n),    32'(err_o[n]), 0);
        chk($sformatf("rst_m%0d_rdata", n),  rd_o[n],       0);
      end
      chk("rst_mem_en",    32'(mem_en),    0);
      chk("rst_mem_write", 32'(mem_write), 0);
      chk("rst_mem_addr",  32'(mem_addr),  0);
      chk("rst_mem_wdata", mem_wdata,      0);
      ptr_m = 0; pend_own = -1; err_pend[0] = 0; err_pend[1] = 0;
    end else begin
      if (req[0] && req[1]) w = RR ? ptr_m : 0;
      else if (req[0])      w = 0;
      else if (req[1])      w = 1;
      for (int n = 0; n < 2; n++) begin
        chk($sformatf("m%0d_gnt", n),    32'(gnt_o[n]), 32'(w == n));
        chk($sformatf("m%0d_err", n),    32'(err_o[n]), 32'(err_pend[n]));
        chk($sformatf("m%0d_rvalid", n), 32'(rv_o[n]),  32'(pend_own == n));
        if (pend_own == n) begin
          chk($sformatf("m%0d_rdata", n), rd_o[n], pend_word);
          hold_m[n] = pend_word; hold_known[n] = 1;
        end else if (hold_known[n]) begin
          chk($sformatf("m%0d_rdata_hold", n), rd_o[n], hold_m[n]);
        end
      end
      pend_own = -1; err_pend[0] = 0; err_pend[1] = 0;
      if (w < 0) begin
        chk("idle_mem_en",    32'(mem_en),    0);
        chk("idle_mem_write", 32'(mem_write), 0);
      end else begin
        nb  = (size[w] == 2'd0) ? 1 : (size[w] == 2'd1) ? 2 : 4;
        a   = int'(addr[w]);
        bad = (size[w] == 2'd3) || (a % nb != 0);
        chk("mem_en", 32'(mem_en), 32'(!bad));
        if (bad) begin
          chk("err_mem_write", 32'(mem_write), 0);
          err_pend[w] = 1;
        end else begin
          chk("mem_addr", 32'(mem_addr), 32'(a / 4));
          if (we[w]) begin
            off = a % 4;
            wr = '0; wd = '0;
            for (int k = 0; k < 4; k++) begin
              if (k >= off && k < off + nb) wr[3-k] = 1'b1;
              wd[8*k +: 8] = wdata[w][8*(k % nb) +: 8];
            end
            chk("st_mem_write", 32'(mem_write), 32'(wr));
            chk("st_mem_wdata", mem_wdata, wd);
            for (int k = 0; k < 4; k++)
              if (wr[3-k]) ref_mem[a/4][8*k +: 8] = wd[8*k +: 8];
          end else begin
            chk("ld_mem_write", 32'(mem_write), 0);
            pend_own  = w;
            pend_word = ref_mem[a/4];
          end
        end
        if (RR) ptr_m = 1 - w;
      end
    end
    last_w = w;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input bit r, input bit w_e, input logic [12:0] a,
                         input logic [1:0] s, input logic [31:0] d);
    req[n] = r; we[n] = w_e; addr[n] = a; size[n] = s; wdata[n] = d;
  endtask

  initial begin
    int sz;
    rst = 1'b1; clr = 1'b1;
    for (int n = 0; n < 2; n++) begin
      set_req(n, 0, 0, '0, 2'd0, '0);
      hold_known[n] = 0; err_pend[n] = 0;
    end
    for (int i = 0; i < 2048; i++) ref_mem[i] = '0;
    ptr_m = 0; pend_own = -1; last_w = -1;

    // Reset state, with a request present that must be ignored.
    cyc(); adv();
    set_req(0, 1, 1, 13'h010, 2'd2, 32'h12345678);
    cyc(); adv();
    clr = 1'b0; rst = 1'b0;
    set_req(0, 0, 0, '0, 2'd0, '0);
    cyc(); adv();

    // m0 store word then load back.
    set_req(0, 1, 1, 13'h010, 2'd2, 32'hDEADBEEF);
    cyc();
    chk("s37_mem_write", 32'(mem_write), 32'b1111);
    chk("s37_mem_addr",  32'(mem_addr),  4);
    adv();
    set_req(0, 1, 0, 13'h010, 2'd2, '0);
    cyc(); adv();
    set_req(0, 0, 0, '0, 2'd0, '0);
    cyc();
    chk("s37_m0_rvalid", 32'(m0_rvalid), 1);
    chk("s37_m0_rdata",  m0_rdata,       32'hDEADBEEF);
    adv();

    // m1 store byte to the top lane of word 4.
    set_req(1, 1, 1, 13'h013, 2'd0, 32'h000000A5);
    cyc();
    chk("s38_mem_wdata", mem_wdata,        32'hA5A5A5A5);
    chk("s38_mem_write", 32'(mem_write),   32'b0001);
    chk("s38_mem_addr",  32'(mem_addr),    4);
    adv();

    // Both requesters load for four cycles.
    set_req(0, 1, 0, 13'h010, 2'd2, '0);
    set_req(1, 1, 0, 13'h014, 2'd2, '0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("s39_m0_gnt", 32'(m0_gnt), RR ? 32'(i % 2 == 0) : 32'd1);
      adv();
    end
    set_req(0, 0, 0, '0, 2'd0, '0);
    set_req(1, 0, 0, '0, 2'd0, '0);
    cyc(); adv();

    // Misaligned word load from m0.
    set_req(0, 1, 0, 13'h002, 2'd2, '0);
    cyc();
    chk("s40_m0_gnt", 32'(m0_gnt), 1);
    chk("s40_mem_en", 32'(mem_en), 0);
    adv();
    set_req(0, 0, 0, '0, 2'd0, '0);
    cyc();
    chk("s40_m0_err",    32'(m0_err),    1);
    chk("s40_m0_rvalid", 32'(m0_rvalid), 0);
    adv();
    cyc();
    chk("s40_m0_err_clr", 32'(m0_err), 0);
    adv();

    // Load granted, reset asserted on the following cycle.
    set_req(0, 1, 0, 13'h010, 2'd2, '0);
    cyc(); adv();
    set_req(0, 0, 0, '0, 2'd0, '0);
    rst = 1'b1;
    cyc();
    chk("s41_m0_rvalid_rst", 32'(m0_rvalid), 0);
    adv();
    rst = 1'b0;
    cyc();
    chk("s41_m0_rvalid_after", 32'(m0_rvalid), 0);
    adv();

    // Randomized traffic; each requester holds its request until granted.
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n] && $urandom_range(0, 2) != 0) begin
          sz = int'($urandom_range(0, 9));
          set_req(n, 1, 1'($urandom_range(0, 1)), 13'($urandom_range(0, 31)),
                  (sz < 3) ? 2'd0 : (sz < 6) ? 2'd1 : (sz < 9) ? 2'd2 : 2'd3, $urandom);
          if ($urandom_range(0, 4) != 0) begin
            if (size[n] == 2'd1) addr[n][0]   = 1'b0;
            if (size[n] == 2'd2) addr[n][1:0] = 2'b00;
          end
        end
      end
      rst = ($urandom_range(0, 59) == 0);
      cyc(); adv();
      if (last_w >= 0) req[last_w] = 1'b0;
    end
    rst = 1'b0;
    set_req(0, 0, 0, '0, 2'd0, '0);
    set_req(1, 0, 0, '0, 2'd0, '0);
    cyc(); adv();
    cyc(); adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
